// File: rtl/disp_pkg.sv
// Shared types for the display arbiter: FSM states, owner codes and the display word.
package disp_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StShowKey = 2'd1,
    StShowMsg = 2'd2
  } state_e;

  typedef logic [1:0] src_t;

  localparam src_t SRC_IDLE = 2'b00;
  localparam src_t SRC_KEY  = 2'b01;
  localparam src_t SRC_MSG  = 2'b10;

  function automatic src_t state_src(state_e s);
    src_t code;
    case (s)
      StShowKey: code = SRC_KEY;
      StShowMsg: code = SRC_MSG;
      default:   code = SRC_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/disp_arbiter_if.sv
// Requester handshakes plus the display-side outputs of the arbiter.
interface disp_arbiter_if;
  import disp_pkg::*;

  logic  key_req;
  word_t key_data;
  logic  key_ack;
  logic  msg_req;
  word_t msg_data;
  logic  msg_ack;
  word_t data;
  src_t  src;
  logic  busy;

  modport master (
    output key_req, key_data, msg_req, msg_data,
    input  key_ack, msg_ack, data, src, busy
  );

  modport slave (
    input  key_req, key_data, msg_req, msg_data,
    output key_ack, msg_ack, data, src, busy
  );

endinterface

// File: rtl/hold_timer.sv
// Loadable down-counter that parks at zero; expire flags zero while the hold is running.
module hold_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_run,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_run && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expire = i_run && (r_count == '0);

endmodule

// File: rtl/disp_arbiter.sv
// Shares the Display7 data word between the key path and a timed, pre-empting message path.
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 50_000_000,
  parameter word_t       DEFAULT_WORD = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  disp_arbiter_if.slave disp
);

  localparam int unsigned CntW = $clog2(HOLD_CYCLES);
  localparam logic [CntW-1:0] LoadVal = CntW'(HOLD_CYCLES - 1);

  state_e r_state, w_state_nxt;
  word_t  r_data, w_data_nxt;
  word_t  r_last_key, w_last_key_nxt;
  logic   r_key_seen, w_key_seen_nxt;
  logic   r_key_ack, w_key_ack_nxt;
  logic   r_msg_ack, w_msg_ack_nxt;
  src_t   r_src;
  logic   r_busy;

  logic w_key_elig, w_msg_elig;
  logic w_load, w_expire;

  // The own-ack term blocks a second accept while the requester still holds req.
  assign w_key_elig = disp.key_req && !r_key_ack;
  assign w_msg_elig = disp.msg_req && !r_msg_ack;

  hold_timer #(
    .WIDTH (CntW)
  ) u_hold_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (LoadVal),
    .i_run      (r_state == StShowMsg),
    .o_expire   (w_expire)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_data_nxt     = r_data;
    w_last_key_nxt = r_last_key;
    w_key_seen_nxt = r_key_seen;
    w_key_ack_nxt  = 1'b0;
    w_msg_ack_nxt  = 1'b0;
    w_load         = 1'b0;

    unique case (r_state)
      StIdle, StShowKey: begin
        if (w_msg_elig) begin
          w_data_nxt    = disp.msg_data;
          w_load        = 1'b1;
          w_msg_ack_nxt = 1'b1;
          w_state_nxt   = StShowMsg;
        end else if (w_key_elig) begin
          w_data_nxt     = disp.key_data;
          w_last_key_nxt = disp.key_data;
          w_key_seen_nxt = 1'b1;
          w_key_ack_nxt  = 1'b1;
          w_state_nxt    = StShowKey;
        end
      end
      StShowMsg: begin
        // Keys are always taken during a hold; they only surface once the hold ends.
        if (w_key_elig) begin
          w_last_key_nxt = disp.key_data;
          w_key_seen_nxt = 1'b1;
          w_key_ack_nxt  = 1'b1;
        end
        if (w_msg_elig) begin
          w_data_nxt    = disp.msg_data;
          w_load        = 1'b1;
          w_msg_ack_nxt = 1'b1;
        end else if (w_expire) begin
          w_data_nxt  = w_key_elig ? disp.key_data : r_last_key;
          w_state_nxt = (w_key_elig || r_key_seen) ? StShowKey : StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_data     <= DEFAULT_WORD;
      r_last_key <= DEFAULT_WORD;
      r_key_seen <= 1'b0;
      r_key_ack  <= 1'b0;
      r_msg_ack  <= 1'b0;
      r_src      <= SRC_IDLE;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_data     <= w_data_nxt;
      r_last_key <= w_last_key_nxt;
      r_key_seen <= w_key_seen_nxt;
      r_key_ack  <= w_key_ack_nxt;
      r_msg_ack  <= w_msg_ack_nxt;
      r_src      <= state_src(w_state_nxt);
      r_busy     <= (w_state_nxt == StShowMsg);
    end
  end

  assign disp.data    = r_data;
  assign disp.src     = r_src;
  assign disp.busy    = r_busy;
  assign disp.key_ack = r_key_ack;
  assign disp.msg_ack = r_msg_ack;

endmodule

// File: doc/disp_arbiter.md
# disp_arbiter

Sequences and shares the 32-bit word driving the `Display7` eight-digit seven-segment driver between two requesters: the keyboard note path (key) and the status/message path (msg). A message pre-empts the key word for a programmable hold time, then the display reverts to the most recent key word. The block sits between the keyboard/status logic and the `data` input of `Display7`.

## Interface
- `HOLD_CYCLES`, default 50_000_000: clock cycles a message remains displayed; legal range ≥ 2.
- `DEFAULT_WORD`, default 32'h0000_0000: word shown after reset, before any key is accepted.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_req`  in  1  key requester has a word pending; held until `key_ack`.
- `key_data`  in  32  key word; stable while `key_req` is high.
- `key_ack`  out  1  one-cycle pulse: key word accepted.
- `msg_req`  in  1  message requester has a word pending; held until `msg_ack`.
- `msg_data`  in  32  message word; stable while `msg_req` is high.
- `msg_ack`  out  1  one-cycle pulse: message word accepted.
- `data`  out  32  registered word to `Display7.data`.
- `src`  out  2  current owner: 2'b00 idle/default, 2'b01 key, 2'b10 msg.
- `busy`  out  1  high while a message hold is running.

## Operation
- States: IDLE (default word), SHOW_KEY, SHOW_MSG.
- Reset: state IDLE; `data`=DEFAULT_WORD; `last_key`=DEFAULT_WORD; `key_ack`=`msg_ack`=0; `src`=00; `busy`=0; hold counter 0. A reset mid-hold aborts the message and discards any pending key.
- Acceptance: a request is eligible when its req is high and its own ack is low (prevents double acceptance in the ack cycle). Eligible requests are accepted on the next edge; ack is high for exactly that following cycle.
- IDLE/SHOW_KEY:
  - msg eligible: `data`←`msg_data`, counter←HOLD_CYCLES−1, →SHOW_MSG, `msg_ack` pulse. msg has priority when both are eligible; key waits.
  - key eligible only: `data`←`key_data`, `last_key`←`key_data`, →SHOW_KEY, `key_ack` pulse.
- SHOW_MSG: counter decrements by 1 each cycle.
  - key eligible: accepted and acked; only `last_key` is updated; `data` is unchanged.
  - msg eligible: retrigger; `data`←new `msg_data`, counter reloaded, `msg_ack` pulse.
  - counter == 0 with no msg eligible: `data`←`last_key`; go to SHOW_KEY if any key has been accepted since reset, otherwise IDLE.
  - Expiry cycle with key eligible: the key is accepted, and `data`/`last_key` take the new `key_data` (new key wins).
  - Expiry cycle with msg eligible: retrigger takes precedence over expiry.
- `src` and `busy` are registered and track the state (SHOW_MSG → `src`=10, `busy`=1).

## Timing
- Accept latency: req sampled high at edge N → `data`, `src`, and ack updated at edge N+1. The requester drops req after seeing ack.
- Message visible for exactly HOLD_CYCLES cycles (edges N+1 through N+HOLD_CYCLES). `data` reverts at edge N+HOLD_CYCLES+1.
- Continuous acceptance rate: at most one accept per source every 2 cycles.
- Counter width is $clog2(HOLD_CYCLES); no wrap occurs because the counter stops at 0 outside SHOW_MSG.

## Structure
- Package `disp_pkg`: state enum (IDLE, SHOW_KEY, SHOW_MSG), `src` codes SRC_IDLE/SRC_KEY/SRC_MSG, and a 32-bit word type.
- Sub-module `hold_timer`: loadable down-counter with `load`, `load_val`, and an `expire` output (count==0 while running), parameterised by width.
- Top-level FSM, `last_key` register, and ack generation live in `disp_arbiter`.

## Test plan
All scenarios use HOLD_CYCLES=8.
- After reset → `data`=32'h0, `src`=00, `busy`=0. Assert `rst` mid-hold → same values on the next edge.
- `key_req` with 32'h0000_ABCD → one-cycle `key_ack`; next edge `data`=32'h0000_ABCD, `src`=01. Holding req through the ack cycle yields no second ack.
- After that key, `msg_req` with 32'hE11E_0000 → `data`=32'hE11E_0000, `busy`=1 for exactly 8 cycles, then `data`=32'h0000_ABCD, `src`=01.
- `key_req` and `msg_req` asserted in the same cycle → `msg_ack` first and the message is shown; `key_ack` follows 1 cycle later; `data` stays on the message until expiry, then shows the new key.
- `key_req` with 32'h1234 during a hold → acked and `data` unchanged; at expiry `data`=32'h1234. A key arriving on the expiry cycle → `data`=that key.
- `msg_req` re-asserted 4 cycles into a hold with 32'h5555 → `data`=32'h5555; the hold restarts for a full 8 cycles.
